// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder arbiter: datapath width,
// requester-ID sizing and the captured response record.
package adder_arb_pkg;

  localparam int DATA_W   = 16;
  localparam int ID_MAX_W = 3;   // enough for up to 8 requesters

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [DATA_W-1:0]   sum;
    logic                cout;
  } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid requester at or after
// ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  always_comb begin : search
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder among NUM_REQ requesters: S1 holds the granted
// operands driving the adder, S2 captures sum/carry with the requester ID.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DATA_W,   // must equal DATA_W (resp_t sum width)
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic               s2_valid;
  resp_t              s2_q;

  logic               s1_open;
  logic               s1_load;
  logic               s2_load;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // S1 may accept on the same edge it hands its op to S2.
  assign s2_load   = s1_valid && (!s2_valid || rsp_ready);
  assign s1_open   = !s1_valid || s2_load;
  assign s1_load   = grant_any && s1_open;
  assign req_ready = s1_open ? grant : '0;
  assign ptr_nxt   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
    end else begin
      if (s1_load) begin
        ptr      <= ptr_nxt;
        s1_id    <= grant_idx;
        add_a    <= req_a[grant_idx*WIDTH +: WIDTH];
        add_b    <= req_b[grant_idx*WIDTH +: WIDTH];
        add_cin  <= req_cin[grant_idx];
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_q     <= '{id: ID_MAX_W'(s1_id), sum: add_sum, cout: add_cout};
      end else if (rsp_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_q.id[ID_W-1:0];
  assign rsp_sum   = s2_q.sum;
  assign rsp_cout  = s2_q.cout;

endmodule
